// File: rtl/des_pkg.sv
// Shared DES tables, decrypt rotation schedule, FSM state type and width constants.
// Bit 63 of a 64-bit word is DES bit 1; table entries are 1-based DES bit positions.
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 28;
  localparam int ROUNDS   = 16;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Right-rotation before decrypt round j (index j-1); undoes the encrypt left shifts.
  localparam logic [1:0] ROT_T [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [BLOCK_W-1:0] ip_f(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] fp_f(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [SUBKEY_W-1:0] e_f(input logic [HALF_W-1:0] x);
    logic [SUBKEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] p_f(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [2*CD_W-1:0] pc1_f(input logic [BLOCK_W-1:0] x);
    logic [2*CD_W-1:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2_f(input logic [2*CD_W-1:0] x);
    logic [SUBKEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [CD_W-1:0] ror_cd(input logic [CD_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[CD_W-1:1]};
      2'd2:    return {x[1:0], x[CD_W-1:2]};
      default: return x;
    endcase
  endfunction

  // High when any key byte has even parity.
  function automatic logic key_par_bad(input logic [BLOCK_W-1:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/des_key_sched_rev.sv
// Reverse DES key schedule: C/D registers rotated right, yielding K16 first.
// Subkeys are combinational from C/D and the completed-round count; C/D advance on step_i.
module des_key_sched_rev
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load_i,
  input  logic [2*CD_W-1:0]                        pc1_i,
  input  logic                                     step_i,
  input  logic [3:0]                               rnd_i,
  output logic [ROUNDS_PER_CYCLE-1:0][SUBKEY_W-1:0] subkey_o
);

  logic [CD_W-1:0] c_q, d_q, c_d, d_d;
  logic [CD_W-1:0] c_r, d_r;
  logic [3:0]      j_r;

  always_comb begin
    c_r      = c_q;
    d_r      = d_q;
    j_r      = '0;
    subkey_o = '0;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      j_r         = rnd_i + 4'(k);
      c_r         = ror_cd(c_r, ROT_T[j_r]);
      d_r         = ror_cd(d_r, ROT_T[j_r]);
      subkey_o[k] = pc2_f({c_r, d_r});
    end
    c_d = c_q;
    d_d = d_q;
    if (load_i) begin
      {c_d, d_d} = pc1_i;
    end else if (step_i) begin
      c_d = c_r;
      d_d = d_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      d_q <= '0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/s_function.sv
// DES S-box layer: 48-bit input to 32-bit output, purely combinational.
// Zero latency; no flow control.
module s_function (
  input  logic [47:0] x_i,
  output logic [31:0] y_o
);

  // Row-major per box: index = {b1, b6, b2..b5}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{4'd14,4'd4,4'd13,4'd1,4'd2,4'd15,4'd11,4'd8,4'd3,4'd10,4'd6,4'd12,4'd5,4'd9,4'd0,4'd7,
      4'd0,4'd15,4'd7,4'd4,4'd14,4'd2,4'd13,4'd1,4'd10,4'd6,4'd12,4'd11,4'd9,4'd5,4'd3,4'd8,
      4'd4,4'd1,4'd14,4'd8,4'd13,4'd6,4'd2,4'd11,4'd15,4'd12,4'd9,4'd7,4'd3,4'd10,4'd5,4'd0,
      4'd15,4'd12,4'd8,4'd2,4'd4,4'd9,4'd1,4'd7,4'd5,4'd11,4'd3,4'd14,4'd10,4'd0,4'd6,4'd13},
    '{4'd15,4'd1,4'd8,4'd14,4'd6,4'd11,4'd3,4'd4,4'd9,4'd7,4'd2,4'd13,4'd12,4'd0,4'd5,4'd10,
      4'd3,4'd13,4'd4,4'd7,4'd15,4'd2,4'd8,4'd14,4'd12,4'd0,4'd1,4'd10,4'd6,4'd9,4'd11,4'd5,
      4'd0,4'd14,4'd7,4'd11,4'd10,4'd4,4'd13,4'd1,4'd5,4'd8,4'd12,4'd6,4'd9,4'd3,4'd2,4'd15,
      4'd13,4'd8,4'd10,4'd1,4'd3,4'd15,4'd4,4'd2,4'd11,4'd6,4'd7,4'd12,4'd0,4'd5,4'd14,4'd9},
    '{4'd10,4'd0,4'd9,4'd14,4'd6,4'd3,4'd15,4'd5,4'd1,4'd13,4'd12,4'd7,4'd11,4'd4,4'd2,4'd8,
      4'd13,4'd7,4'd0,4'd9,4'd3,4'd4,4'd6,4'd10,4'd2,4'd8,4'd5,4'd14,4'd12,4'd11,4'd15,4'd1,
      4'd13,4'd6,4'd4,4'd9,4'd8,4'd15,4'd3,4'd0,4'd11,4'd1,4'd2,4'd12,4'd5,4'd10,4'd14,4'd7,
      4'd1,4'd10,4'd13,4'd0,4'd6,4'd9,4'd8,4'd7,4'd4,4'd15,4'd14,4'd3,4'd11,4'd5,4'd2,4'd12},
    '{4'd7,4'd13,4'd14,4'd3,4'd0,4'd6,4'd9,4'd10,4'd1,4'd2,4'd8,4'd5,4'd11,4'd12,4'd4,4'd15,
      4'd13,4'd8,4'd11,4'd5,4'd6,4'd15,4'd0,4'd3,4'd4,4'd7,4'd2,4'd12,4'd1,4'd10,4'd14,4'd9,
      4'd10,4'd6,4'd9,4'd0,4'd12,4'd11,4'd7,4'd13,4'd15,4'd1,4'd3,4'd14,4'd5,4'd2,4'd8,4'd4,
      4'd3,4'd15,4'd0,4'd6,4'd10,4'd1,4'd13,4'd8,4'd9,4'd4,4'd5,4'd11,4'd12,4'd7,4'd2,4'd14},
    '{4'd2,4'd12,4'd4,4'd1,4'd7,4'd10,4'd11,4'd6,4'd8,4'd5,4'd3,4'd15,4'd13,4'd0,4'd14,4'd9,
      4'd14,4'd11,4'd2,4'd12,4'd4,4'd7,4'd13,4'd1,4'd5,4'd0,4'd15,4'd10,4'd3,4'd9,4'd8,4'd6,
      4'd4,4'd2,4'd1,4'd11,4'd10,4'd13,4'd7,4'd8,4'd15,4'd9,4'd12,4'd5,4'd6,4'd3,4'd0,4'd14,
      4'd11,4'd8,4'd12,4'd7,4'd1,4'd14,4'd2,4'd13,4'd6,4'd15,4'd0,4'd9,4'd10,4'd4,4'd5,4'd3},
    '{4'd12,4'd1,4'd10,4'd15,4'd9,4'd2,4'd6,4'd8,4'd0,4'd13,4'd3,4'd4,4'd14,4'd7,4'd5,4'd11,
      4'd10,4'd15,4'd4,4'd2,4'd7,4'd12,4'd9,4'd5,4'd6,4'd1,4'd13,4'd14,4'd0,4'd11,4'd3,4'd8,
      4'd9,4'd14,4'd15,4'd5,4'd2,4'd8,4'd12,4'd3,4'd7,4'd0,4'd4,4'd10,4'd1,4'd13,4'd11,4'd6,
      4'd4,4'd3,4'd2,4'd12,4'd9,4'd5,4'd15,4'd10,4'd11,4'd14,4'd1,4'd7,4'd6,4'd0,4'd8,4'd13},
    '{4'd4,4'd11,4'd2,4'd14,4'd15,4'd0,4'd8,4'd13,4'd3,4'd12,4'd9,4'd7,4'd5,4'd10,4'd6,4'd1,
      4'd13,4'd0,4'd11,4'd7,4'd4,4'd9,4'd1,4'd10,4'd14,4'd3,4'd5,4'd12,4'd2,4'd15,4'd8,4'd6,
      4'd1,4'd4,4'd11,4'd13,4'd12,4'd3,4'd7,4'd14,4'd10,4'd15,4'd6,4'd8,4'd0,4'd5,4'd9,4'd2,
      4'd6,4'd11,4'd13,4'd8,4'd1,4'd4,4'd10,4'd7,4'd9,4'd5,4'd0,4'd15,4'd14,4'd2,4'd3,4'd12},
    '{4'd13,4'd2,4'd8,4'd4,4'd6,4'd15,4'd11,4'd1,4'd10,4'd9,4'd3,4'd14,4'd5,4'd0,4'd12,4'd7,
      4'd1,4'd15,4'd13,4'd8,4'd10,4'd3,4'd7,4'd4,4'd12,4'd5,4'd6,4'd11,4'd0,4'd14,4'd9,4'd2,
      4'd7,4'd11,4'd4,4'd1,4'd9,4'd12,4'd14,4'd2,4'd0,4'd6,4'd10,4'd13,4'd15,4'd3,4'd5,4'd8,
      4'd2,4'd1,4'd14,4'd7,4'd4,4'd10,4'd8,4'd13,4'd15,4'd12,4'd9,4'd0,4'd3,4'd5,4'd6,4'd11}};

  always_comb begin
    y_o = '0;
    for (int i = 0; i < 8; i++) begin
      y_o[31-4*i -: 4] = SBOX[i][{x_i[47-6*i], x_i[42-6*i], x_i[46-6*i -: 4]}];
    end
  end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption, ROUNDS_PER_CYCLE rounds/clock; out_valid 16/ROUNDS_PER_CYCLE cycles after accept.
// One block in flight; plaintext held until out_ready. DES_DEC_KEY_PARITY_EN adds key_err.
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
`ifdef DES_DEC_KEY_PARITY_EN
  ,
  output logic               key_err
`endif
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d, cnt_nxt;
  logic [HALF_W-1:0]  l_q, r_q, l_d, r_d, l_fin, r_fin;
  logic [BLOCK_W-1:0] out_q, out_d, res_w;
  logic               accept_w, last_w;
  logic [ROUNDS_PER_CYCLE-1:0][SUBKEY_W-1:0] subkey_w;

  assign accept_w = in_valid && (state_q == IDLE);
  assign cnt_nxt  = cnt_q + STEP;
  assign last_w   = (cnt_nxt == 5'(ROUNDS));

  des_key_sched_rev #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_ksched (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept_w),
    .pc1_i    (pc1_f(in_key)),
    .step_i   (state_q == ROUND),
    .rnd_i    (cnt_q[3:0]),
    .subkey_o (subkey_w)
  );

  // Unrolled Feistel chain for the rounds performed this cycle.
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_rnd
    logic [HALF_W-1:0]   l_in, r_in, l_out, r_out, s_out;
    logic [SUBKEY_W-1:0] s_in;
    if (k == 0) begin : g_src
      assign l_in = l_q;
      assign r_in = r_q;
    end else begin : g_src
      assign l_in = g_rnd[k-1].l_out;
      assign r_in = g_rnd[k-1].r_out;
    end
    assign s_in = e_f(r_in) ^ subkey_w[k];
    s_function u_sfn (.x_i(s_in), .y_o(s_out));
    assign l_out = r_in;
    assign r_out = l_in ^ p_f(s_out);
  end

  assign l_fin = g_rnd[ROUNDS_PER_CYCLE-1].l_out;
  assign r_fin = g_rnd[ROUNDS_PER_CYCLE-1].r_out;

`ifdef DES_DEC_KEY_PARITY_EN
  logic perr_q, key_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      if (accept_w) perr_q <= key_par_bad(in_key);
      if (state_q == ROUND && last_w) key_err_q <= perr_q;
      else if (state_q == DONE && out_ready) key_err_q <= 1'b0;
    end
  end

  assign key_err = key_err_q;
  assign res_w   = perr_q ? '0 : fp_f({r_fin, l_fin});
`else
  assign res_w   = fp_f({r_fin, l_fin});
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    l_d       = l_q;
    r_d       = r_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d    = ROUND;
          cnt_d      = '0;
          {l_d, r_d} = ip_f(in_data);
        end
      end
      ROUND: begin
        busy  = 1'b1;
        l_d   = l_fin;
        r_d   = r_fin;
        cnt_d = cnt_nxt;
        if (last_w) begin
          state_d = DONE;
          out_d   = res_w;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core at ROUNDS_PER_CYCLE = 1, 4 and 16 sharing one stimulus stream.
// Expected plaintexts are published DES vectors; latencies are 16/ROUNDS_PER_CYCLE.
module tb_des_decrypt_core;

  localparam int NDUT = 3;
  localparam int RPC [NDUT] = '{1, 4, 16};

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  logic clk, rst, in_valid, out_ready;
  logic [63:0] in_data, in_key;
  logic [NDUT-1:0] ir, ov, bz;
  logic [NDUT-1:0][63:0] od;
`ifdef DES_DEC_KEY_PARITY_EN
  logic [NDUT-1:0] kerr, cap_kerr;
`endif

  int checks = 0;
  int errors = 0;
  int lat [NDUT];
  logic [63:0] cap [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    des_decrypt_core #(.ROUNDS_PER_CYCLE(RPC[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .busy      (bz[g])
`ifdef DES_DEC_KEY_PARITY_EN
      ,
      .key_err   (kerr[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block for exactly one accepting edge; returns #1 after that edge.
  task automatic send(input logic [63:0] k, input logic [63:0] d);
    in_key   = k;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Record the first out_valid cycle (counted from the accept edge) and its data.
  task automatic capture(input int ncyc, input bit stop_all);
    for (int g = 0; g < NDUT; g++) begin
      lat[g] = 0;
      cap[g] = '0;
    end
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NDUT; g++) begin
        if (ov[g] && lat[g] == 0) begin
          lat[g] = n;
          cap[g] = od[g];
`ifdef DES_DEC_KEY_PARITY_EN
          cap_kerr[g] = kerr[g];
`endif
        end
      end
      if (stop_all && ov == '1) break;
    end
  endtask

  task automatic check_cap(input string tag, input logic [63:0] exp);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("%s_lat_r%0d", tag, RPC[g]), 64'(lat[g]), 64'(16 / RPC[g]));
      chk($sformatf("%s_dat_r%0d", tag, RPC[g]), cap[g], exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("rst_in_ready_r%0d", RPC[g]), 64'(ir[g]), 64'h1);
      chk($sformatf("rst_out_valid_r%0d", RPC[g]), 64'(ov[g]), 64'h0);
      chk($sformatf("rst_busy_r%0d", RPC[g]), 64'(bz[g]), 64'h0);
      chk($sformatf("rst_out_data_r%0d", RPC[g]), od[g], 64'h0);
    end
    rst = 1'b0;

    // Known vector, downstream always ready.
    out_ready = 1'b1;
    send(K1, C1);
    chk("v1_busy_after_accept", 64'(bz), 64'h7);
    chk("v1_in_ready_after_accept", 64'(ir), 64'h0);
    in_data = ~C1;
    in_key  = ~K1;
    capture(24, 1'b0);
    check_cap("v1", P1);
    chk("v1_out_valid_dropped", 64'(ov), 64'h0);
    chk("v1_out_data_retained", od[0], P1);
    chk("v1_idle_again", 64'(ir), 64'h7);

    // Second vector under backpressure.
    out_ready = 1'b0;
    send(K2, C2);
    capture(24, 1'b1);
    check_cap("v2bp", P2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid_c%0d", c), 64'(ov), 64'h7);
      chk($sformatf("bp_hold_in_ready_c%0d", c), 64'(ir), 64'h0);
      for (int g = 0; g < NDUT; g++)
        chk($sformatf("bp_hold_data_c%0d_r%0d", c, RPC[g]), od[g], P2);
    end

    // Handshake cycle with a new block already offered: it must not be taken yet.
    in_key = K1; in_data = C1; in_valid = 1'b1; out_ready = 1'b1;
    chk("hs_in_ready_in_done", 64'(ir), 64'h0);
    @(posedge clk); #1;
    chk("hs_in_ready_after", 64'(ir), 64'h7);
    chk("hs_out_valid_after", 64'(ov), 64'h0);
    chk("hs_busy_after", 64'(bz), 64'h0);
    chk("hs_data_retained", od[0], P2);

    // Accept now, then reset while the R=1 core is about to run round 7.
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("mid_busy_after_accept", 64'(bz), 64'h7);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_valid_r1_c%0d", c), 64'(ov[0]), 64'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(ov), 64'h0);
    chk("mid_rst_in_ready", 64'(ir), 64'h7);
    chk("mid_rst_busy", 64'(bz), 64'h0);
    chk("mid_rst_out_data_r16", od[2], 64'h0);

    // Fresh block after the aborted one.
    out_ready = 1'b1;
    send(K2, C2);
    capture(24, 1'b0);
    check_cap("post_rst", P2);

`ifdef DES_DEC_KEY_PARITY_EN
    send(64'h133457799BBCDFF0, C1);
    capture(24, 1'b0);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("par_bad_lat_r%0d", RPC[g]), 64'(lat[g]), 64'(16 / RPC[g]));
      chk($sformatf("par_bad_kerr_r%0d", RPC[g]), 64'(cap_kerr[g]), 64'h1);
      chk($sformatf("par_bad_dat_r%0d", RPC[g]), cap[g], 64'h0);
    end
    chk("par_kerr_cleared", 64'(kerr), 64'h0);
    send(K1, C1);
    capture(24, 1'b0);
    check_cap("par_good", P1);
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("par_good_kerr_r%0d", RPC[g]), 64'(cap_kerr[g]), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
